// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared constants, FSM encoding and checksum helper for the tally read-out path
package vote_pkg;
   localparam int NUM_CANDIDATES = 4;
   localparam int VOTE_W = 8;
   localparam int FRAME_BYTES = 6;
   localparam logic [7:0] DEFAULT_FRAME_HEADER = 8'hA5;

   typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} tx_state_t;

   // Truncation to VOTE_W gives the modulo-256 wrap.
   function automatic logic [VOTE_W-1:0] tally_checksum(
      input logic [VOTE_W-1:0] a,
      input logic [VOTE_W-1:0] b,
      input logic [VOTE_W-1:0] c,
      input logic [VOTE_W-1:0] d
   );
      return a + b + c + d;
   endfunction
endpackage

// File: rtl/vote_result_tx_if.sv
// rtl/vote_result_tx_if.sv - control, tally and serial-line signals of the result reporter
interface vote_result_tx_if;
   import vote_pkg::*;

   logic              mode;
   logic              start;
   logic [VOTE_W-1:0] cand1_votes;
   logic [VOTE_W-1:0] cand2_votes;
   logic [VOTE_W-1:0] cand3_votes;
   logic [VOTE_W-1:0] cand4_votes;
   logic              tx;
   logic              busy;
   logic              done;

   modport master (
      output mode, start, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
      input  tx, busy, done
   );

   modport slave (
      input  mode, start, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
      output tx, busy, done
   );
endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 serializer for one byte; a load in the stop-bit wrap cycle chains the next byte with no gap
module uart_byte_tx
   import vote_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_t         r_state, w_state_next;
   logic [BAUD_W-1:0] r_baud, w_baud_next;
   logic [2:0]        r_bit, w_bit_next;
   logic [7:0]        r_shift, w_shift_next;
   logic              r_tx, w_tx_next;
   logic              w_wrap;

   assign w_wrap = (r_baud == BAUD_MAX);
   assign tx     = r_tx;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = (r_state == IDLE || w_wrap) ? '0 : r_baud + 1'b1;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_tx_next    = r_tx;
      byte_done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_state_next = START_BIT;
               w_shift_next = data;
               w_tx_next    = 1'b0;
            end
         end
         START_BIT: begin
            if (w_wrap) begin
               w_state_next = DATA_BITS;
               w_bit_next   = '0;
               w_tx_next    = r_shift[0];
            end
         end
         DATA_BITS: begin
            if (w_wrap) begin
               if (r_bit == 3'd7) begin
                  w_state_next = STOP_BIT;
                  w_tx_next    = 1'b1;
               end else begin
                  w_bit_next   = r_bit + 3'd1;
                  w_shift_next = r_shift >> 1;
                  w_tx_next    = r_shift[1];
               end
            end
         end
         STOP_BIT: begin
            if (w_wrap) begin
               byte_done = 1'b1;
               if (load) begin
                  w_state_next = START_BIT;
                  w_shift_next = data;
                  w_tx_next    = 1'b0;
               end else begin
                  w_state_next = IDLE;
                  w_tx_next    = 1'b1;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end
endmodule

// File: rtl/vote_result_tx.sv
// rtl/vote_result_tx.sv - snapshots the four tallies and sends header, tallies and checksum as a 6-byte UART frame
module vote_result_tx
   import vote_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 10,
   parameter logic [7:0] FRAME_HEADER = DEFAULT_FRAME_HEADER
) (
   input logic             clock,
   input logic             reset,
   vote_result_tx_if.slave bus
);
   logic [VOTE_W-1:0] r_snap [NUM_CANDIDATES];
   logic [VOTE_W-1:0] r_csum;
   logic [2:0]        r_idx;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;
   logic              w_byte_done;
   logic              w_last_byte;
   logic              w_load;
   logic [2:0]        w_next_idx;
   logic [7:0]        w_byte;
   logic              w_tx;

   assign w_accept    = bus.start & bus.mode & ~r_busy;
   assign w_last_byte = (r_idx == 3'(FRAME_BYTES - 1));
   assign w_next_idx  = r_idx + 3'd1;
   assign w_load      = w_accept | (w_byte_done & ~w_last_byte);

   // Byte 0 is loaded on acceptance; later bytes are loaded as the previous stop bit ends.
   always_comb begin
      w_byte = FRAME_HEADER;
      if (!w_accept) begin
         case (w_next_idx)
            3'd1:    w_byte = r_snap[0];
            3'd2:    w_byte = r_snap[1];
            3'd3:    w_byte = r_snap[2];
            3'd4:    w_byte = r_snap[3];
            3'd5:    w_byte = r_csum;
            default: w_byte = FRAME_HEADER;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CANDIDATES; i++) r_snap[i] <= '0;
         r_csum <= '0;
         r_idx  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_snap[0] <= bus.cand1_votes;
            r_snap[1] <= bus.cand2_votes;
            r_snap[2] <= bus.cand3_votes;
            r_snap[3] <= bus.cand4_votes;
            r_csum    <= tally_checksum(bus.cand1_votes, bus.cand2_votes,
                                        bus.cand3_votes, bus.cand4_votes);
            r_busy    <= 1'b1;
            r_idx     <= '0;
         end else if (w_byte_done) begin
            if (w_last_byte) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_idx  <= '0;
            end else begin
               r_idx <= w_next_idx;
            end
         end
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clock     (clock),
      .reset     (reset),
      .load      (w_load),
      .data      (w_byte),
      .tx        (w_tx),
      .byte_done (w_byte_done)
   );

   assign bus.tx   = w_tx;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule
